// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: glyph patterns (bit 6 = g ... bit 0 = a),
// the decoder FSM states and the lookup result record.
package seven_seg_pkg;

    localparam logic [6:0] SEG_PAT_0 = 7'h3F;
    localparam logic [6:0] SEG_PAT_1 = 7'h06;
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;
    localparam logic [6:0] SEG_PAT_3 = 7'h4F;
    localparam logic [6:0] SEG_PAT_4 = 7'h66;
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;
    localparam logic [6:0] SEG_PAT_6 = 7'h7D;
    localparam logic [6:0] SEG_PAT_7 = 7'h07;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h67;
    localparam logic [6:0] SEG_PAT_A = 7'h77;
    localparam logic [6:0] SEG_PAT_B = 7'h7C;
    localparam logic [6:0] SEG_PAT_C = 7'h39;
    localparam logic [6:0] SEG_PAT_D = 7'h5E;
    localparam logic [6:0] SEG_PAT_E = 7'h79;
    localparam logic [6:0] SEG_PAT_F = 7'h71;

    // All segments dark; reported as a blank display, not as an error.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        IDLE,
        SETTLE
    } seg_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] value;
    } seg_lookup_t;

endpackage

// File: rtl/seven_seg_pattern_lookup.sv
// Combinational reverse table: 7-segment glyph -> hex digit.
// Only the canonical glyphs hit; alternate renderings are misses.
module seven_seg_pattern_lookup
    import seven_seg_pkg::*;
(
    input  logic [6:0]  seg_i,
    output seg_lookup_t result_o
);

    // Match the pattern against the sixteen canonical glyphs.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        result_o = '{hit: 1'b0, value: 4'h0};
        case (seg_i)
            SEG_PAT_0: result_o = '{hit: 1'b1, value: 4'h0};
            SEG_PAT_1: result_o = '{hit: 1'b1, value: 4'h1};
            SEG_PAT_2: result_o = '{hit: 1'b1, value: 4'h2};
            SEG_PAT_3: result_o = '{hit: 1'b1, value: 4'h3};
            SEG_PAT_4: result_o = '{hit: 1'b1, value: 4'h4};
            SEG_PAT_5: result_o = '{hit: 1'b1, value: 4'h5};
            SEG_PAT_6: result_o = '{hit: 1'b1, value: 4'h6};
            SEG_PAT_7: result_o = '{hit: 1'b1, value: 4'h7};
            SEG_PAT_8: result_o = '{hit: 1'b1, value: 4'h8};
            SEG_PAT_9: result_o = '{hit: 1'b1, value: 4'h9};
            SEG_PAT_A: result_o = '{hit: 1'b1, value: 4'hA};
            SEG_PAT_B: result_o = '{hit: 1'b1, value: 4'hB};
            SEG_PAT_C: result_o = '{hit: 1'b1, value: 4'hC};
            SEG_PAT_D: result_o = '{hit: 1'b1, value: 4'hD};
            SEG_PAT_E: result_o = '{hit: 1'b1, value: 4'hE};
            SEG_PAT_F: result_o = '{hit: 1'b1, value: 4'hF};
            default:   result_o = '{hit: 1'b0, value: 4'h0};
        endcase
    end

endmodule

// File: rtl/seven_seg_to_binary_decoder.sv
// Samples an asynchronous 7-segment bundle, waits until it has been steady
// for STABLE_CYCLES synchronized cycles, then reports it once as a hex value
// (o_VALID pulse), an unknown glyph (o_ERROR pulse) or a dark display (o_BLANK).
module seven_seg_to_binary_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_SEG_0,
    input  logic       i_SEG_1,
    input  logic       i_SEG_2,
    input  logic       i_SEG_3,
    input  logic       i_SEG_4,
    input  logic       i_SEG_5,
    input  logic       i_SEG_6,
    output logic [3:0] o_BINARY,
    output logic       o_VALID,
    output logic       o_ERROR,
    output logic       o_BLANK
);

    localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       seg_async;
    logic [6:0]       sync1_q;
    logic [6:0]       sync2_q;

    seg_state_e       state_q, state_d;
    logic [6:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       binary_q, binary_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             blank_q, blank_d;

    seg_lookup_t      lookup;

    assign seg_async = {i_SEG_6, i_SEG_5, i_SEG_4, i_SEG_3, i_SEG_2, i_SEG_1, i_SEG_0};

    // Two-flop synchronizer; a torn bundle only restarts the settle window.
    always_ff @(posedge i_CLK) begin
        // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
        if (i_RST) begin
            sync1_q <= SEG_BLANK;
            sync2_q <= SEG_BLANK;
        end else begin
            sync1_q <= seg_async;
            sync2_q <= sync1_q;
        end
    end

    seven_seg_pattern_lookup u_lookup (
        .seg_i    (last_q),
        .result_o (lookup)
    );

    // State, settle tracking and registered outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= IDLE;
            last_q   <= SEG_BLANK;
            cnt_q    <= '0;
            binary_q <= 4'h0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            blank_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            blank_q  <= blank_d;
        end
    end

    // Next-state logic: detect a change, count the settle window, classify once.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        blank_d  = blank_q;

        case (state_q)
            IDLE: begin
                if (sync2_q != last_q) begin
                    last_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sync2_q != last_q) begin
                    // Pattern moved before settling: restart on the new value.
                    last_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    if (lookup.hit) begin
                        binary_d = lookup.value;
                        valid_d  = 1'b1;
                        blank_d  = 1'b0;
                    end else if (last_q == SEG_BLANK) begin
                        blank_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        blank_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_BINARY = binary_q;
    assign o_VALID  = valid_q;
    assign o_ERROR  = error_q;
    assign o_BLANK  = blank_q;

endmodule

// File: tb/tb_seven_seg_to_binary_decoder.sv
// Randomized bench for seven_seg_to_binary_decoder. The reference model keeps
// the per-edge input history and, at every edge, looks back for a run of one
// pattern that began exactly 2+S edges ago and lasted at least S+1 edges.
module tb_seven_seg_to_binary_decoder;

    localparam int S = 4;
    localparam logic [6:0] DIGIT_PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_drv;
    logic [3:0] o_binary;
    logic       o_valid, o_error, o_blank;

    always #5 clk = ~clk;

    seven_seg_to_binary_decoder #(.STABLE_CYCLES(S)) dut (
        .i_CLK    (clk),
        .i_RST    (rst),
        .i_SEG_0  (seg_drv[0]),
        .i_SEG_1  (seg_drv[1]),
        .i_SEG_2  (seg_drv[2]),
        .i_SEG_3  (seg_drv[3]),
        .i_SEG_4  (seg_drv[4]),
        .i_SEG_5  (seg_drv[5]),
        .i_SEG_6  (seg_drv[6]),
        .o_BINARY (o_binary),
        .o_VALID  (o_valid),
        .o_ERROR  (o_error),
        .o_BLANK  (o_blank)
    );

    int total = 0;
    int bad   = 0;

    // Model state.
    logic [6:0] hist [0:8191];
    int         edge_n   = -1;
    int         last_rst = -1;
    logic [3:0] exp_bin;
    logic       exp_valid, exp_err, exp_blank;

    // Per-scenario observations.
    logic [3:0] valid_vals [$];
    int         valid_edges [$];
    int         err_cnt;

    function automatic int find_digit(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (DIGIT_PAT[i] == p) return i;
        return -1;
    endfunction

    // One clock: drive pins, advance the model, compare every output after the edge.
    task automatic tick(input logic [6:0] seg, input logic r);
        int  k;
        int  d;
        bit  stable;
        seg_drv = seg;
        rst     = r;
        @(posedge clk);
        edge_n++;
        hist[edge_n] = r ? 7'h00 : seg;
        if (r) begin
            last_rst  = edge_n;
            exp_bin   = 4'h0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_blank = 1'b1;
        end else begin
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            k = edge_n - 2 - S;
            if (k > last_rst && hist[k] != hist[k-1]) begin
                stable = 1'b1;
                for (int j = k; j <= k + S; j++)
                    if (hist[j] != hist[k]) stable = 1'b0;
                if (stable) begin
                    d = find_digit(hist[k]);
                    if (d >= 0) begin
                        exp_bin   = 4'(d);
                        exp_valid = 1'b1;
                        exp_blank = 1'b0;
                    end else if (hist[k] == 7'h00) begin
                        exp_blank = 1'b1;
                    end else begin
                        exp_err   = 1'b1;
                        exp_blank = 1'b0;
                    end
                end
            end
        end
        #1;
        total++;
        if ({o_valid, o_error, o_blank, o_binary} !== {exp_valid, exp_err, exp_blank, exp_bin}) begin
            bad++;
            $display("FAIL cycle edge=%0d got v=%b e=%b blank=%b bin=%h want v=%b e=%b blank=%b bin=%h",
                     edge_n, o_valid, o_error, o_blank, o_binary, exp_valid, exp_err, exp_blank, exp_bin);
        end
        if (o_valid === 1'b1) begin
            valid_vals.push_back(o_binary);
            valid_edges.push_back(edge_n);
        end
        if (o_error === 1'b1) err_cnt++;
    endtask

    task automatic clear_obs();
        valid_vals.delete();
        valid_edges.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(7'($urandom), 1'b1);
        total++;
        if ({o_binary, o_blank, o_valid, o_error} !== {4'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got bin=%h blank=%b v=%b e=%b want bin=0 blank=1 v=0 e=0",
                     o_binary, o_blank, o_valid, o_error);
        end
        clear_obs();
        for (int i = 0; i < 20; i++) tick(7'h00, 1'b0);
        total++;
        if (valid_vals.size() != 0 || err_cnt != 0) begin
            bad++;
            $display("FAIL reset_idle_pulses got valid=%0d err=%0d want 0 0", valid_vals.size(), err_cnt);
        end
    endtask

    task automatic test_single_digit();
        int k0;
        clear_obs();
        k0 = edge_n + 1;
        for (int i = 0; i < 10; i++) tick(7'h5B, 1'b0);
        total++;
        if (valid_vals.size() != 1 || valid_edges[0] != k0 + 6 || valid_vals[0] !== 4'h2 || o_blank !== 1'b0) begin
            bad++;
            $display("FAIL single_digit got pulses=%0d edge=%0d bin=%h blank=%b want 1 pulse at edge %0d bin=2 blank=0",
                     valid_vals.size(), (valid_edges.size() > 0) ? valid_edges[0] : -1, o_binary, o_blank, k0 + 6);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        for (int i = 0; i < 2; i++)  tick(7'h06, 1'b0);
        for (int i = 0; i < 10; i++) tick(7'h4F, 1'b0);
        total++;
        if (valid_vals.size() != 1 || valid_vals[0] !== 4'h3 || err_cnt != 0) begin
            bad++;
            $display("FAIL glitch got pulses=%0d first=%h err=%0d want 1 pulse bin=3 err=0",
                     valid_vals.size(), (valid_vals.size() > 0) ? valid_vals[0] : 4'hx, err_cnt);
        end
    endtask

    task automatic test_invalid();
        clear_obs();
        for (int i = 0; i < 10; i++) tick(7'h6F, 1'b0);
        total++;
        if (err_cnt != 1 || valid_vals.size() != 0 || o_binary !== 4'h3 || o_blank !== 1'b0) begin
            bad++;
            $display("FAIL invalid got err=%0d valid=%0d bin=%h blank=%b want err=1 valid=0 bin=3 blank=0",
                     err_cnt, valid_vals.size(), o_binary, o_blank);
        end
    endtask

    task automatic test_sweep();
        int wrong;
        clear_obs();
        for (int d = 0; d < 16; d++)
            for (int i = 0; i < 8; i++) tick(DIGIT_PAT[d], 1'b0);
        for (int i = 0; i < 10; i++) tick(7'h00, 1'b0);
        wrong = 0;
        if (valid_vals.size() == 16)
            for (int d = 0; d < 16; d++)
                if (valid_vals[d] !== 4'(d)) wrong++;
        total++;
        if (valid_vals.size() != 16 || wrong != 0 || err_cnt != 0 || o_blank !== 1'b1 || o_binary !== 4'hF) begin
            bad++;
            $display("FAIL sweep got pulses=%0d misordered=%0d err=%0d blank=%b bin=%h want 16 0 0 1 F",
                     valid_vals.size(), wrong, err_cnt, o_blank, o_binary);
        end
    endtask

    task automatic test_reset_mid_settle();
        clear_obs();
        tick(7'h7D, 1'b0);
        tick(7'h7D, 1'b0);
        tick(7'h7D, 1'b1);
        tick(7'h7D, 1'b1);
        total++;
        if (valid_vals.size() != 0 || {o_binary, o_blank, o_valid, o_error} !== {4'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_settle_reset got pulses=%0d bin=%h blank=%b v=%b e=%b want 0 0 1 0 0",
                     valid_vals.size(), o_binary, o_blank, o_valid, o_error);
        end
        for (int i = 0; i < 10; i++) tick(7'h7D, 1'b0);
        total++;
        if (valid_vals.size() != 1 || valid_vals[0] !== 4'h6) begin
            bad++;
            $display("FAIL mid_settle_release got pulses=%0d first=%h want 1 pulse bin=6",
                     valid_vals.size(), (valid_vals.size() > 0) ? valid_vals[0] : 4'hx);
        end
    endtask

    task automatic test_random();
        logic [6:0] p;
        int         sel;
        int         len;
        for (int run = 0; run < 200; run++) begin
            sel = $urandom_range(0, 99);
            if (sel < 50)      p = DIGIT_PAT[$urandom_range(0, 15)];
            else if (sel < 65) p = 7'h00;
            else               p = 7'($urandom);
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) tick(p, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_glitch();
        test_invalid();
        test_sweep();
        test_reset_mid_settle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
